// File: rtl/srff_bist.sv
// srff_bist: drives s/r into an external SR flip-flop, checks its q against a reference model, counts mismatches.
// Latency: one run takes 2 + 2*NUM_VECS + 1 cycles from the accepted start edge to the end of the done pulse.
// Backpressure: none; start is ignored unless the block is idle. Optional LFSR vectors: define SRFF_BIST_LFSR_EN.
module srff_bist #(
    parameter int         NUM_VECS  = 16,
    parameter int         ERR_W     = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             s_out,
    output logic             r_out,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       first_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_DRV,
        S_INIT_CHK,
        S_DRV,
        S_CHK,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_VECS - 1);
    localparam logic [7:0] FF_NONE  = 8'hFF;
    localparam logic [7:0] FF_INIT  = 8'hFE;

    // Reject parameter values the index width and LFSR cannot support.
    if (NUM_VECS < 1 || NUM_VECS > 255) begin : g_bad_num_vecs
        $error("srff_bist: NUM_VECS must be in 1..255");
    end
    if (LFSR_SEED == 8'h00) begin : g_bad_seed
        $error("srff_bist: LFSR_SEED must be nonzero");
    end

    state_t           state;
    logic [7:0]       idx;        // index of the vector currently applied
    logic             exp_q;      // reference model of the flip-flop state
    logic [1:0]       issue_vec;  // {s,r} for the vector about to be issued
    logic             issue_q;    // reference state after issue_vec is applied
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

`ifdef SRFF_BIST_LFSR_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;
    logic       to_drv;

    // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register.
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign issue_vec = lfsr[1:0];
    assign to_drv    = (state == S_INIT_CHK) || ((state == S_CHK) && (idx != LAST_IDX));

    // Seed on an accepted start, advance once each time a vector is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else if ((state == S_IDLE) && start) begin
            lfsr <= LFSR_SEED;
        end else if (to_drv) begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end
`else
    logic [1:0] issue_sel;

    // Fixed pattern: the next vector index mod 4 selects 10, 00, 01, 11.
    always_comb begin
        issue_sel = (state == S_CHK) ? (idx[1:0] + 2'd1) : 2'd0;
        case (issue_sel)
            2'd0:    issue_vec = 2'b10;
            2'd1:    issue_vec = 2'b00;
            2'd2:    issue_vec = 2'b01;
            default: issue_vec = 2'b11;
        endcase
    end
`endif

    // Reference flip-flop: set on 10, reset on 01, hold on 00 and 11.
    always_comb begin
        issue_q = exp_q;
        case (issue_vec)
            2'b10:   issue_q = 1'b1;
            2'b01:   issue_q = 1'b0;
            default: issue_q = exp_q;
        endcase
    end

    // Case inequality so an unknown q_in is reported as a mismatch in simulation.
    assign mismatch = (q_in !== exp_q);
    assign err_next = (&err_count) ? err_count : (err_count + ERR_W'(1));

    // Run sequencer with registered drive, status and error bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            idx        <= 8'd0;
            exp_q      <= 1'b0;
            s_out      <= 1'b0;
            r_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= FF_NONE;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_INIT_DRV;
                        busy       <= 1'b1;
                        err_count  <= '0;
                        pass       <= 1'b0;
                        first_fail <= FF_NONE;
                        idx        <= 8'd0;
                        // Init vector 01 forces the flip-flop to a known 0.
                        s_out      <= 1'b0;
                        r_out      <= 1'b1;
                        exp_q      <= 1'b0;
                    end
                end
                S_INIT_DRV: begin
                    state <= S_INIT_CHK;
                end
                S_INIT_CHK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (first_fail == FF_NONE) begin
                            first_fail <= FF_INIT;
                        end
                    end
                    {s_out, r_out} <= issue_vec;
                    exp_q          <= issue_q;
                    state          <= S_DRV;
                end
                S_DRV: begin
                    state <= S_CHK;
                end
                S_CHK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (first_fail == FF_NONE) begin
                            first_fail <= idx;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        // Verdict includes this final comparison.
                        state <= S_DONE;
                        done  <= 1'b1;
                        s_out <= 1'b0;
                        r_out <= 1'b0;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        idx            <= idx + 8'd1;
                        {s_out, r_out} <= issue_vec;
                        exp_q          <= issue_q;
                        state          <= S_DRV;
                    end
                end
                S_DONE: begin
                    // A start seen here is dropped; a new run must start from idle.
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srff_bist.sv
// Bench for srff_bist: behavioural SR flip-flop beside the DUT, fault injection on q, and a reference model
// built from the vector rules (pattern or LFSR), checked with immediate assertions.
module tb_srff_bist;

    localparam int NV     = 16;
    localparam int DONE_K = 2 + 2 * NV + 1;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic       s_out, r_out, q_in, busy, done, pass;
    logic [7:0] err_count, first_fail;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   force_mode = 0;    // 0: real flip-flop, 1: stuck at 0, 2: stuck at 1
    logic corrupt    = 1'b0; // inverts q for the current compare window
    logic q_ff       = 1'b0;

    logic [1:0] vec_e  [NV];
    logic       expq_e [NV+1]; // entry 0 is the init vector, entry i+1 is vector i

    srff_bist #(.NUM_VECS(NV), .ERR_W(8), .LFSR_SEED(8'hA5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .s_out      (s_out),
        .r_out      (r_out),
        .q_in       (q_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;

    // Flip-flop under test, behavioural.
    always @(posedge clk) begin
        if (s_out && !r_out) q_ff <= 1'b1;
        else if (!s_out && r_out) q_ff <= 1'b0;
    end

    assign q_in = (force_mode == 1) ? 1'b0 : (force_mode == 2) ? 1'b1 : (q_ff ^ corrupt);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_model();
        int   q;
        int   pat [4];
        pat[0] = 2; pat[1] = 0; pat[2] = 1; pat[3] = 3;
`ifdef SRFF_BIST_LFSR_EN
        begin
            int lf;
            lf = 'hA5;
            for (int i = 0; i < NV; i++) begin
                vec_e[i] = 2'(lf % 4);
                lf = ((lf * 2) + (((lf >> 7) ^ (lf >> 5) ^ (lf >> 4) ^ (lf >> 3)) & 1)) % 256;
            end
        end
`else
        for (int i = 0; i < NV; i++) vec_e[i] = 2'(pat[i % 4]);
`endif
        q = 0;
        expq_e[0] = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (vec_e[i] == 2'b10) q = 1;
            else if (vec_e[i] == 2'b01) q = 0;
            expq_e[i+1] = q[0];
        end
    endtask

    // One full run; dup_at pulses start mid-run, on_done pulses start during the done cycle.
    task automatic run(input string tag, input logic [NV:0] mask, input int fmode, input int dup_at,
                       input bit on_done, output logic [7:0] o_err, output logic [7:0] o_ff,
                       output logic o_pass);
        int   exp_err, exp_ff, done_cyc, ndone;
        bit   seq_ok, busy_ok;
        logic obs;
        logic [1:0] es;
        exp_err = 0;
        exp_ff  = 255;
        for (int j = 0; j <= NV; j++) begin
            obs = (fmode == 1) ? 1'b0 : (fmode == 2) ? 1'b1 : (expq_e[j] ^ mask[j]);
            if (obs !== expq_e[j]) begin
                exp_err++;
                if (exp_ff == 255) exp_ff = (j == 0) ? 254 : j - 1;
            end
        end
        force_mode = fmode;
        o_err = 8'h00; o_ff = 8'h00; o_pass = 1'b0;
        seq_ok = 1; busy_ok = 1; done_cyc = 0; ndone = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 2) es = 2'b01;
            else if (k <= 2 + 2 * NV) es = vec_e[(k - 3) / 2];
            else es = 2'b00;
            if ({s_out, r_out} !== es) seq_ok = 0;
            if ((k <= DONE_K) && (busy !== 1'b1)) busy_ok = 0;
            if ((k > DONE_K) && (busy !== 1'b0)) busy_ok = 0;
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (k == DONE_K) begin
                o_err = err_count; o_ff = first_fail; o_pass = pass;
            end
            if (k == 2) corrupt = mask[0];
            else if (k >= 4 && k <= 2 + 2 * NV && (k % 2) == 0) corrupt = mask[(k - 4) / 2 + 1];
            else corrupt = 1'b0;
            if (dup_at != 0 && k == dup_at) start = 1'b1;
            if (dup_at != 0 && k == dup_at + 1) start = 1'b0;
            if (on_done && k == DONE_K) start = 1'b1;
            if (on_done && k == DONE_K + 1) start = 1'b0;
        end
        chk({tag, " seq"}, 32'(seq_ok), 32'd1);
        chk({tag, " busy"}, 32'(busy_ok), 32'd1);
        chk({tag, " done_cycle"}, 32'(done_cyc), 32'(DONE_K));
        chk({tag, " done_count"}, 32'(ndone), 32'd1);
        chk({tag, " err_count"}, 32'(o_err), 32'(exp_err));
        chk({tag, " first_fail"}, 32'(o_ff), 32'(exp_ff));
        chk({tag, " pass"}, 32'(o_pass), 32'(exp_err == 0));
        chk({tag, " pass_held"}, 32'(pass), 32'(exp_err == 0));
        force_mode = 0;
    endtask

    initial begin
        logic [7:0] e, f;
        logic       p;
        logic [NV:0] m;
        bit idle_ok;
        build_model();

        // Reset and idle.
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst first_fail", 32'(first_fail), 32'hFF);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel s_r", 32'({s_out, r_out}), 32'd0);
        chk("rel done", 32'(done), 32'd0);
        chk("rel pass", 32'(pass), 32'd0);
        chk("rel err_count", 32'(err_count), 32'd0);
        chk("rel first_fail", 32'(first_fail), 32'hFF);
        idle_ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((busy !== 1'b0) || (done !== 1'b0) || ({s_out, r_out} !== 2'b00)) idle_ok = 0;
        end
        chk("idle 20", 32'(idle_ok), 32'd1);

        // Golden, stuck-at, busy-start and start-on-done runs.
        run("golden", '0, 0, 0, 1'b0, e, f, p);
        run("stuck0", '0, 1, 0, 1'b0, e, f, p);
`ifndef SRFF_BIST_LFSR_EN
        chk("stuck0 err 8", 32'(e), 32'd8);
        chk("stuck0 ff 0", 32'(f), 32'd0);
`endif
        run("stuck1", '0, 2, 0, 1'b0, e, f, p);
`ifndef SRFF_BIST_LFSR_EN
        chk("stuck1 err 9", 32'(e), 32'd9);
        chk("stuck1 ff FE", 32'(f), 32'hFE);
`endif
        run("start_busy", '0, 0, 4, 1'b0, e, f, p);
        run("start_done", '0, 0, 0, 1'b1, e, f, p);

        // Reset in the middle of a run.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst s_r", 32'({s_out, r_out}), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst err", 32'(err_count), 32'd0);
        chk("midrst ff", 32'(first_fail), 32'hFF);
        idle_ok = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) idle_ok = 0;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) idle_ok = 0;
        end
        chk("midrst no done", 32'(idle_ok), 32'd1);
        run("after_rst", '0, 0, 0, 1'b0, e, f, p);

        // Random q corruption patterns with random idle gaps.
        for (int r = 0; r < 6; r++) begin
            m = (NV+1)'({$urandom, $urandom} & {$urandom, $urandom});
            if (r % 3 == 0) m = '0;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run("random", m, 0, 0, 1'b0, e, f, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/srff_bist.md
# srff_bist

Self-checking stimulus driver and response checker for the single-bit SR flip-flop. It drives `s`/`r` into an `srff` instance, samples its `q`, and compares `q` against an internal reference model. It also counts mismatches and reports pass/fail. It sits beside the flip-flop in lab top-levels as the on-chip counterpart to the simulation bench.

## Interface
- `NUM_VECS`, 16: vectors applied per run, excluding the init vector; range 1..255.
- `ERR_W`, 8: width of the error counter.
- `LFSR_SEED`, 8'hA5: LFSR start value, used only with `SRFF_BIST_LFSR_EN`; must be nonzero.

Ports:
- `clk` input 1: single clock, rising edge; shared with the flip-flop under test.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a run; ignored while `busy`=1.
- `s_out` input-facing output 1: registered drive to the flip-flop's `s`.
- `r_out` output 1: registered drive to the flip-flop's `r`.
- `q_in` input 1: the flip-flop's `q`.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse at the end of a run.
- `pass` output 1: 1 when `err_count`==0 at `done`; held until the next accepted `start`.
- `err_count` output `ERR_W`: saturating mismatch count.
- `first_fail` output 8: vector index of the first mismatch; 8'hFF means none; init vector is index 8'hFE.

## Operation
- Reset values: `s_out`=0, `r_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail`=8'hFF. State is IDLE.
- States:
  - IDLE: accepted `start` → INIT_DRV. On entry, clears `err_count`, `pass`, `first_fail`, and the vector index. Loads the LFSR with `LFSR_SEED`.
  - INIT_DRV: drive `{s,r}`=01 → INIT_CHK.
  - INIT_CHK: hold 01; expected q=0; compare → DRV.
  - DRV: drive the vector for the current index → CHK.
  - CHK: hold the same `{s,r}` and compare `q_in` to expected.
    - If index==`NUM_VECS`-1 → DONE.
    - Otherwise increment the index and → DRV.
  - DONE: `done`=1 for one cycle, `pass` updated, `s_out`=`r_out`=0 → IDLE.
- Vector pattern (macro off): index mod 4 gives `{s,r}`:
  - 0 → 10
  - 1 → 00
  - 2 → 01
  - 3 → 11
- Reference model, updated when a vector is issued:
  - 10 → 1
  - 01 → 0
  - 00 → hold
  - 11 → hold; the flip-flop holds on 11 and never goes X.
- Mismatch handling:
  - `err_count` increments and saturates at all-ones.
  - `first_fail` is written only while it reads 8'hFF.
  - A `q_in` of X/Z counts as a mismatch in simulation.

## Timing
- Each vector takes 2 cycles.
  - `s_out`/`r_out` change on the edge that enters DRV.
  - The flip-flop captures them on the next edge (end of DRV).
  - `q_in` is compared on the edge ending CHK.
- Run length from the accepted `start` edge to the `done` pulse: 2 + 2·`NUM_VECS` + 1 cycles.
- `busy` rises on the edge after `start` and falls on the edge that ends `done`.
- `start` coinciding with `done` is ignored. A new run needs `start` while in IDLE.
- `reset_n` low at any point: immediate return to the reset values. The run is lost and `done` is not pulsed.

## Configuration
- `SRFF_BIST_LFSR_EN` defined:
  - Vectors come from an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, loaded with `LFSR_SEED`.
  - `{s,r}` = LFSR[1:0].
  - The LFSR advances once per DRV entry.
  - The reference model applies unchanged.
- Not defined: the fixed mod-4 pattern above. No LFSR logic is present.

## Test plan
- Reset and idle: hold `reset_n`=0 for 2 cycles, then release.
  - Expect `s_out`=`r_out`=`busy`=`done`=0, `first_fail`=8'hFF.
  - Expect `start`=0 to leave the block idle for 20 cycles.
- Golden run, `NUM_VECS`=16, connected to a correct `srff`: pulse `start`.
  - Expect `done` exactly 35 cycles after the `start` edge.
  - Expect `pass`=1, `err_count`=0.
  - Expect `{s_out,r_out}` sequence 01,01,10,10,00,00,01,01,11,11,…
- Fault injection: force `q_in`=0 permanently.
  - Expected-1 vectors are indices 0,1,4,5,8,9,12,13, so expect `err_count`=8.
  - Expect `first_fail`=0, `pass`=0.
- Stuck-at-1: force `q_in`=1.
  - Init vector fails, so expect `first_fail`=8'hFE.
  - Expect `err_count`=9.
- Reset mid-run: assert `reset_n`=0 at cycle 10 of a run.
  - Expect outputs to return to reset values asynchronously and no `done` pulse.
  - A following `start` must complete with `pass`=1.
- `start` while busy: pulse `start` at cycle 5 of a run.
  - Expect no restart: `done` still arrives at cycle 35 with `err_count`=0.
- With `SRFF_BIST_LFSR_EN` defined and seed 8'hA5: compare `{s_out,r_out}` against a bench LFSR model. Expect `pass`=1.
